// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter among NUM_REQ byte sources, with
// multi-byte frame locking, a tx_done watchdog and a deferred baud-divisor update.
module uart_tx_scheduler #(
  parameter int          NUM_REQ     = 4,
  parameter logic [12:0] DEFAULT_DIV = 13'd433,
  parameter int          TIMEOUT_CYC = 131072
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [8*NUM_REQ-1:0]       req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         ack,
  output logic                       tx_start,
  output logic [7:0]                 tx_data,
  input  logic                       tx_done,
  output logic [12:0]                uart_ctrl_tx,
  input  logic                       cfg_wr,
  input  logic [12:0]                cfg_div,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       err_timeout
);
  localparam int IDW = $clog2(NUM_REQ);
  localparam int WDW = $clog2(TIMEOUT_CYC);
  localparam logic [WDW-1:0] WD_LIMIT = WDW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, START, WAIT, HOLD} state_e;

  state_e           state_q, state_d;
  logic [IDW-1:0]   last_grant_q, last_grant_d;
  logic [IDW-1:0]   grant_id_q, grant_id_d;
  logic             lock_q, lock_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic             tx_start_q, tx_start_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             err_q, err_d;
  logic [WDW-1:0]   wd_q, wd_d;
  logic [12:0]      div_q, div_d;
  logic [12:0]      pend_div_q, pend_div_d;
  logic             pend_valid_q, pend_valid_d;

  logic             win_found;
  logic [IDW-1:0]   win_idx;
  logic [IDW-1:0]   cand;
  logic             cfg_ok;

  // First requester at or after last_grant+1, wrapping modulo NUM_REQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDW'((int'(last_grant_q) + k) % NUM_REQ);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign cfg_ok = cfg_wr && (cfg_div != 13'd0);

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    lock_d       = lock_q;
    tx_data_d    = tx_data_q;
    ack_d        = '0;
    tx_start_d   = 1'b0;
    err_d        = 1'b0;
    wd_d         = (wd_q == WD_LIMIT) ? wd_q : wd_q + WDW'(1);
    div_d        = div_q;
    pend_div_d   = pend_div_q;
    pend_valid_d = pend_valid_q;

    case (state_q)
      IDLE: begin
        if (win_found) begin
          tx_data_d      = req_data[8*win_idx +: 8];
          ack_d[win_idx] = 1'b1;
          grant_id_d     = win_idx;
          last_grant_d   = win_idx;
          lock_d         = ~req_last[win_idx];
          state_d        = START;
        end
      end
      START: begin
        tx_start_d = 1'b1;
        state_d    = WAIT;
      end
      WAIT: begin
        // tx_done takes priority over a watchdog expiry in the same cycle
        if (tx_done) begin
          state_d = lock_q ? HOLD : IDLE;
        end else if (wd_q == WD_LIMIT) begin
          err_d   = 1'b1;
          lock_d  = 1'b0;
          state_d = IDLE;
        end
      end
      HOLD: begin
        if (req[grant_id_q]) begin
          tx_data_d         = req_data[8*grant_id_q +: 8];
          ack_d[grant_id_q] = 1'b1;
          lock_d            = ~req_last[grant_id_q];
          state_d           = START;
        end else if (wd_q == WD_LIMIT) begin
          err_d   = 1'b1;
          lock_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d != state_q) wd_d = '0;

    // Divisor changes only reach the transmitter while it is idle.
    if (state_q == IDLE) begin
      if (cfg_ok) div_d = cfg_div;
    end else if (state_d == IDLE) begin
      if (cfg_ok) div_d = cfg_div;
      else if (pend_valid_q) div_d = pend_div_q;
      pend_valid_d = 1'b0;
    end else if (cfg_ok) begin
      pend_div_d   = cfg_div;
      pend_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= IDW'(NUM_REQ - 1);
      grant_id_q   <= '0;
      lock_q       <= 1'b0;
      ack_q        <= '0;
      tx_start_q   <= 1'b0;
      tx_data_q    <= 8'h00;
      err_q        <= 1'b0;
      wd_q         <= '0;
      div_q        <= DEFAULT_DIV;
      pend_div_q   <= 13'd0;
      pend_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
      lock_q       <= lock_d;
      ack_q        <= ack_d;
      tx_start_q   <= tx_start_d;
      tx_data_q    <= tx_data_d;
      err_q        <= err_d;
      wd_q         <= wd_d;
      div_q        <= div_d;
      pend_div_q   <= pend_div_d;
      pend_valid_q <= pend_valid_d;
    end
  end

  assign ack          = ack_q;
  assign tx_start     = tx_start_q;
  assign tx_data      = tx_data_q;
  assign err_timeout  = err_q;
  assign grant_id     = grant_id_q;
  assign uart_ctrl_tx = div_q;
  assign busy         = (state_q != IDLE);

endmodule
